orientation_sequencer: RTL
==========================

Name: orientation_sequencer

Overview:
Controller that sequences one rover-heading measurement for the orientation_math datapath. It captures the rover's polar position from the ultrasound locator, commands a short forward move, waits for the rover to settle, and captures the new position. It then pulses the math block's enable, waits for its done, and latches the 5-bit orientation (units of 15 deg, 0..23). It sits between the locator, the rover IR/RF command transmitter and orientation_math in the main FPGA.

Parameters:
SETTLE_CYCLES, 13500000, cycles to wait after move_cmd before accepting the final position (0.5 s at 27 MHz)
TIMEOUT_CYCLES, 54000000, maximum cycles spent in any wait state before aborting (2 s)
COUNT_WIDTH, 26, width of the shared cycle counter; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a measurement; sampled only in IDLE
r_theta_in  in  12  locator sample; r is [7:0], theta is [11:8]
r_theta_valid  in  1  r_theta_in valid this cycle
math_done  in  1  done from orientation_math
orientation_in  in  5  orientation from orientation_math
r_theta_original  out  12  registered first position, drives math block
r_theta_final  out  12  registered second position, drives math block
math_enable  out  1  one-cycle enable pulse to orientation_math
move_cmd  out  1  one-cycle pulse: rover drives forward
orientation  out  5  last successful result
orientation_valid  out  1  high from successful completion until next accepted start
busy  out  1  high in every state except IDLE
error  out  1  high from abort until next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset in any state returns to IDLE on the next edge and drops all pulses; the in-flight measurement is discarded.
- States: IDLE, WAIT_ORIG, MOVE, SETTLE, WAIT_FINAL, CALC, WAIT_DONE, ABORT.
- IDLE: if start, go to WAIT_ORIG, clear orientation_valid and error, and zero the counter. Otherwise hold. start in other states is ignored.
- WAIT_ORIG: on r_theta_valid, latch r_theta_in into r_theta_original and go to MOVE. The first valid sample wins, including one arriving in the first WAIT_ORIG cycle.
- MOVE: move_cmd=1 for exactly this cycle, zero the counter, go to SETTLE.
- SETTLE: increment the counter. r_theta_valid is ignored. When counter==SETTLE_CYCLES-1, zero the counter and go to WAIT_FINAL. SETTLE lasts exactly SETTLE_CYCLES cycles.
- WAIT_FINAL: on r_theta_valid, latch r_theta_final. If the sample equals r_theta_original, the rover did not move: go to ABORT. Otherwise go to CALC.
- CALC: math_enable=1 for exactly this cycle, zero the counter, go to WAIT_DONE. r_theta_original and r_theta_final stay stable from CALC until the next accepted start.
- WAIT_DONE: sample math_done from the cycle after CALC onward. On math_done, latch orientation_in into orientation, set orientation_valid=1 on the next edge, and go to IDLE.
- Timeouts: in WAIT_ORIG, WAIT_FINAL and WAIT_DONE the counter increments each cycle. At counter==TIMEOUT_CYCLES-1 with no qualifying event, go to ABORT. If the qualifying event and the terminal count land in the same cycle, the event wins.
- ABORT: set error=1, go to IDLE, leave orientation at its prior value, keep orientation_valid=0.
- Latency with immediate inputs: start(t) → WAIT_ORIG(t+1) → move_cmd(t+2) → SETTLE(t+3 .. t+2+SETTLE_CYCLES) → WAIT_FINAL(t+3+SETTLE_CYCLES). Then sample → math_enable one cycle later → math_done → orientation_valid one cycle later.
- math_enable and move_cmd are never high in the same cycle. Each pulses at most once per measurement.
- busy=0 exactly when the state is IDLE. error and orientation_valid are mutually exclusive.

Test Plan:
- Nominal (SETTLE=4, TIMEOUT=20): start, orig=12'h364, final=12'h580, math_done 6 cycles after enable with orientation_in=7 → one move_cmd, one math_enable, orientation=7, orientation_valid=1, busy=0, error=0.
- No movement: orig=final=12'h364 → no math_enable, error=1, orientation unchanged from the previous run (7), orientation_valid=0.
- Locator silent after start (TIMEOUT=20) → error=1 exactly 20 cycles after entering WAIT_ORIG, no move_cmd.
- r_theta_valid held high throughout SETTLE with 12'h111 → r_theta_final is the first sample after SETTLE, not 12'h111. SETTLE lasts exactly 4 cycles.
- start pulsed while busy, then reset asserted mid-SETTLE → start ignored; the edge after reset gives all outputs 0 and IDLE. A new start then completes normally.
- math_done at the terminal-count cycle of WAIT_DONE with orientation_in=23 → success: orientation=23, error=0.

Source files
------------

// File: rtl/orientation_sequencer.sv
// Sequences one rover-heading measurement: capture position, move, settle,
// capture again, run orientation_math and latch its 5-bit result.
module orientation_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 13500000,
  parameter int unsigned TIMEOUT_CYCLES = 54000000,
  parameter int unsigned COUNT_WIDTH    = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] r_theta_in,
  input  logic        r_theta_valid,
  input  logic        math_done,
  input  logic [4:0]  orientation_in,
  output logic [11:0] r_theta_original,
  output logic [11:0] r_theta_final,
  output logic        math_enable,
  output logic        move_cmd,
  output logic [4:0]  orientation,
  output logic        orientation_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ORIG,
    MOVE,
    SETTLE,
    WAIT_FINAL,
    CALC,
    WAIT_DONE,
    ABORT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST  = COUNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic [11:0]            original_next, final_next;
  logic [4:0]             orientation_next;
  logic                   valid_next, error_next;
  logic                   at_timeout, at_settle_end;

  assign at_timeout    = (count == TIMEOUT_LAST);
  assign at_settle_end = (count == SETTLE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      r_theta_original  <= '0;
      r_theta_final     <= '0;
      orientation       <= '0;
      orientation_valid <= 1'b0;
      error             <= 1'b0;
    end else begin
      state             <= state_next;
      count             <= count_next;
      r_theta_original  <= original_next;
      r_theta_final     <= final_next;
      orientation       <= orientation_next;
      orientation_valid <= valid_next;
      error             <= error_next;
    end
  end

  // Events are tested before the terminal count so a same-cycle event wins.
  always_comb begin
    state_next       = state;
    count_next       = count;
    original_next    = r_theta_original;
    final_next       = r_theta_final;
    orientation_next = orientation;
    valid_next       = orientation_valid;
    error_next       = error;
    move_cmd         = 1'b0;
    math_enable      = 1'b0;
    busy             = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT_ORIG;
          count_next = '0;
          valid_next = 1'b0;
          error_next = 1'b0;
        end
      end
      WAIT_ORIG: begin
        if (r_theta_valid) begin
          original_next = r_theta_in;
          state_next    = MOVE;
        end else if (at_timeout) begin
          state_next = ABORT;
          error_next = 1'b1;
        end else begin
          count_next = count + COUNT_WIDTH'(1);
        end
      end
      MOVE: begin
        move_cmd   = 1'b1;
        count_next = '0;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (at_settle_end) begin
          count_next = '0;
          state_next = WAIT_FINAL;
        end else begin
          count_next = count + COUNT_WIDTH'(1);
        end
      end
      WAIT_FINAL: begin
        if (r_theta_valid) begin
          final_next = r_theta_in;
          if (r_theta_in == r_theta_original) begin
            state_next = ABORT;
            error_next = 1'b1;
          end else begin
            state_next = CALC;
          end
        end else if (at_timeout) begin
          state_next = ABORT;
          error_next = 1'b1;
        end else begin
          count_next = count + COUNT_WIDTH'(1);
        end
      end
      CALC: begin
        math_enable = 1'b1;
        count_next  = '0;
        state_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (math_done) begin
          orientation_next = orientation_in;
          valid_next       = 1'b1;
          state_next       = IDLE;
        end else if (at_timeout) begin
          state_next = ABORT;
          error_next = 1'b1;
        end else begin
          count_next = count + COUNT_WIDTH'(1);
        end
      end
      ABORT: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
